alu_op_sequencer: RTL and testbench

Single-clock sequencer that drives the ALU control strobes (operand load, operation select, carry/BCD, result drive) for one requested operation across 1–4 chained bytes.
- Carry is chained between bytes.
- Honours the RDY stall.
- Sits between a debug/microcode request port and the ALU datapath. It replaces hand-timed strobe generation for multi-byte test and utility sequences.

---
 rtl/alu_op_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps the ALU control strobes through one requested
// operation over 1..MAXB chained bytes. Each byte takes three states:
// LOAD (operand strobes), OPER (op select, carry-in, BCD adjust) and
// STORE (result drive, carry capture). An illegal op goes straight to FIN
// and flags err.
//
// Stall model: strobes are registered, so a cycle's strobes are fixed at
// the edge that starts it. rdy sampled at the end of a LOAD/OPER/STORE
// cycle therefore decides whether the *following* cycle executes.
// - A non-executing cycle (exec_q=0) shows the state with every strobe
//   inactive, and it does not advance state, idx or cout.
// - The first cycle that follows the stall re-runs the held state in full.
module alu_op_sequencer #(
  parameter int MAXB = 4,
  parameter int OPW  = 3
) (
  input  logic                      PHI0,
  input  logic                      n_RES,
  input  logic                      req,
  input  logic [OPW-1:0]            op,
  input  logic                      cin,
  input  logic                      dec,
  input  logic                      sub,
  input  logic [$clog2(MAXB)-1:0]   nbytes,
  input  logic                      rdy,
  input  logic                      n_COUT,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(MAXB)-1:0]   byte_idx,
  output logic                      cout,
  output logic                      SB_ADD,
  output logic                      DB_ADD,
  output logic                      NDB_ADD,
  output logic                      ANDS,
  output logic                      EORS,
  output logic                      ORS,
  output logic                      SRS,
  output logic                      SUMS,
  output logic                      n_ACIN,
  output logic                      n_DAA,
  output logic                      n_DSA,
  output logic                      ADD_SB06,
  output logic                      ADD_SB7
);

  localparam int IDXW = $clog2(MAXB);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_OPER  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [OPW-1:0] OP_SUM = OPW'(0);
  localparam logic [OPW-1:0] OP_AND = OPW'(1);
  localparam logic [OPW-1:0] OP_OR  = OPW'(2);
  localparam logic [OPW-1:0] OP_EOR = OPW'(3);
  localparam logic [OPW-1:0] OP_SR  = OPW'(4);
  localparam logic [OPW-1:0] OP_ROR = OPW'(5);

  // Shifts walk the bytes MSB first and take no B operand.
  function automatic logic is_shift(input logic [OPW-1:0] o);
    return (o == OP_SR) || (o == OP_ROR);
  endfunction

  logic [2:0]      state_q, state_d;
  logic            exec_q, exec_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            dec_q, dec_d;
  logic            sub_q, sub_d;
  logic [IDXW-1:0] nb_q, nb_d;
  logic            ill_q, ill_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            cout_q, cout_d;

  logic sb_add_q, sb_add_d, db_add_q, db_add_d, ndb_add_q, ndb_add_d;
  logic ands_q, ands_d, eors_q, eors_d, ors_q, ors_d, srs_q, srs_d, sums_q, sums_d;
  logic n_acin_q, n_acin_d, n_daa_q, n_daa_d, n_dsa_q, n_dsa_d;
  logic add_sb06_q, add_sb06_d, add_sb7_q, add_sb7_d;

  logic shift_q;
  logic last_byte;

  assign shift_q   = is_shift(op_q);
  assign last_byte = shift_q ? (idx_q == '0) : (idx_q == nb_q);

  // Sequencing: request capture, state walk, byte index and carry chain.
  always_comb begin
    state_d = state_q;
    exec_d  = exec_q;
    op_d    = op_q;
    dec_d   = dec_q;
    sub_d   = sub_q;
    nb_d    = nb_q;
    ill_d   = ill_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        exec_d = 1'b0;
        if (req) begin
          if (op <= OP_ROR) begin
            op_d    = op;
            dec_d   = dec;
            sub_d   = sub;
            nb_d    = nbytes;
            ill_d   = 1'b0;
            cout_d  = cin;
            idx_d   = is_shift(op) ? nbytes : '0;
            exec_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            ill_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_LOAD: begin
        exec_d = rdy;
        if (exec_q) state_d = S_OPER;
      end
      S_OPER: begin
        exec_d = rdy;
        if (exec_q) state_d = S_STORE;
      end
      S_STORE: begin
        exec_d = rdy;
        if (exec_q) begin
          // Logical ops leave the carry alone; SUM and shifts capture it.
          if ((op_q == OP_SUM) || shift_q) cout_d = ~n_COUT;
          if (last_byte) begin
            state_d = S_FIN;
          end else begin
            idx_d   = shift_q ? (idx_q - IDXW'(1)) : (idx_q + IDXW'(1));
            state_d = S_LOAD;
          end
        end
      end
      S_FIN: begin
        exec_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        exec_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobe decode from the state about to be entered, so the registered
  // strobes cover the whole state cycle; non-executing cycles stay quiet.
  always_comb begin
    sb_add_d   = 1'b0;
    db_add_d   = 1'b0;
    ndb_add_d  = 1'b0;
    ands_d     = 1'b0;
    eors_d     = 1'b0;
    ors_d      = 1'b0;
    srs_d      = 1'b0;
    sums_d     = 1'b0;
    n_acin_d   = 1'b1;
    n_daa_d    = 1'b1;
    n_dsa_d    = 1'b1;
    add_sb06_d = 1'b0;
    add_sb7_d  = 1'b0;
    if (exec_d) begin
      case (state_d)
        S_LOAD: begin
          sb_add_d = 1'b1;
          if (!is_shift(op_d)) begin
            if (sub_d) ndb_add_d = 1'b1;
            else       db_add_d  = 1'b1;
          end
        end
        S_OPER: begin
          case (op_d)
            OP_SUM:  sums_d = 1'b1;
            OP_AND:  ands_d = 1'b1;
            OP_OR:   ors_d  = 1'b1;
            OP_EOR:  eors_d = 1'b1;
            default: srs_d  = 1'b1;
          endcase
          if (op_d == OP_SUM) begin
            n_acin_d = ~cout_d;
            if (dec_d) begin
              if (sub_d) n_dsa_d = 1'b0;
              else       n_daa_d = 1'b0;
            end
          end
        end
        S_STORE: begin
          add_sb06_d = 1'b1;
          // Shifts get bit 7 from outside (ROR feeds the old carry there).
          add_sb7_d  = !is_shift(op_d);
        end
        default: ;
      endcase
    end
  end

  // State, latched request fields and registered strobes.
  always_ff @(posedge PHI0) begin
    if (!n_RES) begin
      state_q    <= S_IDLE;
      exec_q     <= 1'b0;
      op_q       <= '0;
      dec_q      <= 1'b0;
      sub_q      <= 1'b0;
      nb_q       <= '0;
      ill_q      <= 1'b0;
      idx_q      <= '0;
      cout_q     <= 1'b0;
      sb_add_q   <= 1'b0;
      db_add_q   <= 1'b0;
      ndb_add_q  <= 1'b0;
      ands_q     <= 1'b0;
      eors_q     <= 1'b0;
      ors_q      <= 1'b0;
      srs_q      <= 1'b0;
      sums_q     <= 1'b0;
      n_acin_q   <= 1'b1;
      n_daa_q    <= 1'b1;
      n_dsa_q    <= 1'b1;
      add_sb06_q <= 1'b0;
      add_sb7_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exec_q     <= exec_d;
      op_q       <= op_d;
      dec_q      <= dec_d;
      sub_q      <= sub_d;
      nb_q       <= nb_d;
      ill_q      <= ill_d;
      idx_q      <= idx_d;
      cout_q     <= cout_d;
      sb_add_q   <= sb_add_d;
      db_add_q   <= db_add_d;
      ndb_add_q  <= ndb_add_d;
      ands_q     <= ands_d;
      eors_q     <= eors_d;
      ors_q      <= ors_d;
      srs_q      <= srs_d;
      sums_q     <= sums_d;
      n_acin_q   <= n_acin_d;
      n_daa_q    <= n_daa_d;
      n_dsa_q    <= n_dsa_d;
      add_sb06_q <= add_sb06_d;
      add_sb7_q  <= add_sb7_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign err      = (state_q == S_FIN) && ill_q;
  assign byte_idx = idx_q;
  assign cout     = cout_q;
  assign SB_ADD   = sb_add_q;
  assign DB_ADD   = db_add_q;
  assign NDB_ADD  = ndb_add_q;
  assign ANDS     = ands_q;
  assign EORS     = eors_q;
  assign ORS      = ors_q;
  assign SRS      = srs_q;
  assign SUMS     = sums_q;
  assign n_ACIN   = n_acin_q;
  assign n_DAA    = n_daa_q;
  assign n_DSA    = n_dsa_q;
  assign ADD_SB06 = add_sb06_q;
  assign ADD_SB7  = add_sb7_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer. Each request is expanded by a
// step-list reference model into one expected record per busy cycle; a
// monitor pops and compares a record every cycle the DUT reports busy.
module tb_alu_op_sequencer;

  logic       clk;
  logic       n_RES, req, cin, dec, sub, rdy, n_COUT;
  logic [2:0] op;
  logic [1:0] nbytes;
  logic       busy, done, err, cout;
  logic [1:0] byte_idx;
  logic       SB_ADD, DB_ADD, NDB_ADD, ANDS, EORS, ORS, SRS, SUMS;
  logic       n_ACIN, n_DAA, n_DSA, ADD_SB06, ADD_SB7;

  alu_op_sequencer dut (
    .PHI0(clk), .n_RES(n_RES), .req(req), .op(op), .cin(cin), .dec(dec),
    .sub(sub), .nbytes(nbytes), .rdy(rdy), .n_COUT(n_COUT),
    .busy(busy), .done(done), .err(err), .byte_idx(byte_idx), .cout(cout),
    .SB_ADD(SB_ADD), .DB_ADD(DB_ADD), .NDB_ADD(NDB_ADD),
    .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS), .SUMS(SUMS),
    .n_ACIN(n_ACIN), .n_DAA(n_DAA), .n_DSA(n_DSA),
    .ADD_SB06(ADD_SB06), .ADD_SB7(ADD_SB7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe vector: {SB_ADD,DB_ADD,NDB_ADD,ANDS,EORS,ORS,SRS,SUMS,n_ACIN,n_DAA,n_DSA,ADD_SB06,ADD_SB7}
  localparam logic [12:0] IDLE_STRB = {8'h00, 3'b111, 2'b00};

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] idx;
    logic       cout;
    logic [12:0] strb;
  } rec_t;

  logic [12:0] act_strb;
  assign act_strb = {SB_ADD, DB_ADD, NDB_ADD, ANDS, EORS, ORS, SRS, SUMS,
                     n_ACIN, n_DAA, n_DSA, ADD_SB06, ADD_SB7};

  rec_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 0;
  bit   rdy_sched[128];
  bit   ncout_sched[128];
  logic m_cout, m_idx_b0, m_idx_b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Strobes that one step of a byte must show: 0=operand load, 1=operate, 2=store.
  function automatic logic [12:0] step_strobes(input int kind, input logic [2:0] o,
                                               input logic d, input logic s, input logic cy);
    logic sb, db, ndb, an, eo, orr, sr, su, nac, ndaa, ndsa, s06, s7, shift;
    shift = (o == 3'd4) || (o == 3'd5);
    {sb, db, ndb, an, eo, orr, sr, su, s06, s7} = '0;
    nac = 1'b1; ndaa = 1'b1; ndsa = 1'b1;
    case (kind)
      0: begin
        sb  = 1'b1;
        db  = !shift && !s;
        ndb = !shift && s;
      end
      1: begin
        su = (o == 3'd0); an = (o == 3'd1); orr = (o == 3'd2); eo = (o == 3'd3); sr = shift;
        if (o == 3'd0) begin
          nac  = ~cy;
          ndaa = !(d && !s);
          ndsa = !(d && s);
        end
      end
      default: begin
        s06 = 1'b1;
        s7  = !shift;
      end
    endcase
    return {sb, db, ndb, an, eo, orr, sr, su, nac, ndaa, ndsa, s06, s7};
  endfunction

  task automatic sched_clean();
    for (int i = 0; i < 128; i++) begin
      rdy_sched[i]   = 1'b1;
      ncout_sched[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sched_random();
    for (int i = 0; i < 128; i++) begin
      rdy_sched[i]   = (i > 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ncout_sched[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Issue one request: expand it into expected records, then drive it.
  // reset_at>0 pulls n_RES low during that cycle after acceptance.
  task automatic run_txn(input logic [2:0] t_op, input logic t_cin, input logic t_dec,
                         input logic t_sub, input logic [1:0] t_nb,
                         input int reset_at, input bit noisy);
    rec_t e;
    int c, pos, nsteps, ncyc;
    bit ex, shift;
    logic [1:0] bidx, m_idx;
    m_idx = {m_idx_b1, m_idx_b0};
    if (t_op >= 3'd6) begin
      e = '{busy: 1'b1, done: 1'b1, err: 1'b1, idx: m_idx, cout: m_cout, strb: IDLE_STRB};
      exp_q.push_back(e);
      ncyc = 1;
    end else begin
      shift  = (t_op == 3'd4) || (t_op == 3'd5);
      m_cout = t_cin;
      nsteps = 3 * (int'(t_nb) + 1);
      pos = 0; ex = 1'b1; c = 1;
      while (1) begin
        bidx  = shift ? (t_nb - 2'(pos / 3)) : 2'(pos / 3);
        m_idx = bidx;
        e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.idx = bidx; e.cout = m_cout;
        e.strb = ex ? step_strobes(pos % 3, t_op, t_dec, t_sub, m_cout) : IDLE_STRB;
        exp_q.push_back(e);
        if (ex) begin
          if ((pos % 3 == 2) && (t_op == 3'd0 || shift)) m_cout = ~ncout_sched[c];
          pos++;
        end
        if (pos == nsteps) break;
        ex = rdy_sched[c];
        c++;
      end
      c++;
      e = '{busy: 1'b1, done: 1'b1, err: 1'b0, idx: m_idx, cout: m_cout, strb: IDLE_STRB};
      exp_q.push_back(e);
      ncyc = c;
    end
    {m_idx_b1, m_idx_b0} = m_idx;

    @(negedge clk);
    req = 1'b1; op = t_op; cin = t_cin; dec = t_dec; sub = t_sub; nbytes = t_nb;
    @(negedge clk);
    req = 1'b0;
    for (int cc = 1; cc <= ncyc; cc++) begin
      rdy    = rdy_sched[cc];
      n_COUT = ncout_sched[cc];
      if (noisy) begin
        req = ($urandom_range(0, 2) == 0);
        op = 3'($urandom); cin = 1'($urandom); dec = 1'($urandom);
        sub = 1'($urandom); nbytes = 2'($urandom);
      end
      if (cc == ncyc && reset_at == 0) req = 1'b1;
      if (cc == reset_at) begin
        req = 1'b0;
        n_RES = 1'b0;
        exp_q.delete();
        m_cout = 1'b0; m_idx_b0 = 1'b0; m_idx_b1 = 1'b0;
        @(negedge clk);
        n_RES = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_idx", 32'(byte_idx), 32'd0);
        chk("rst_strb", 32'(act_strb), 32'(IDLE_STRB));
        break;
      end
      @(negedge clk);
    end
    req = 1'b0;
    rdy = 1'b1;
    chk("leftover_records", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: one record per busy cycle; quiet outputs otherwise.
  initial begin
    rec_t e, a;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      a = {busy, done, err, byte_idx, cout, act_strb};
      if (busy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_busy: got busy=1 idx=%0d strb=%b, required idle", byte_idx, act_strb);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_record: got done=%b err=%b idx=%0d cout=%b strb=%b, required done=%b err=%b idx=%0d cout=%b strb=%b",
                     a.done, a.err, a.idx, a.cout, a.strb, e.done, e.err, e.idx, e.cout, e.strb);
          end
        end
      end else begin
        n_vec++;
        if ({done, err, act_strb} !== {2'b00, IDLE_STRB}) begin
          n_fail++;
          $display("FAIL idle_quiet: got done=%b err=%b strb=%b, required 0 0 %b",
                   done, err, act_strb, IDLE_STRB);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_RES = 1'b0; req = 1'b0; op = 3'd0; cin = 1'b0; dec = 1'b0; sub = 1'b0;
    nbytes = 2'd0; rdy = 1'b1; n_COUT = 1'b1;
    m_cout = 1'b0; m_idx_b0 = 1'b0; m_idx_b1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_idx", 32'(byte_idx), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_strb", 32'(act_strb), 32'(IDLE_STRB));
    @(negedge clk);
    n_RES = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Two-byte SUM, carry out of byte 0 chained into byte 1.
    sched_clean(); ncout_sched[3] = 1'b0;
    run_txn(3'd0, 1'b1, 1'b0, 1'b0, 2'd1, 0, 0);
    // BCD subtract, then AND holding the carry.
    sched_clean(); run_txn(3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 0, 0);
    sched_clean(); run_txn(3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 0, 0);
    // Rotate right over three bytes, MSB first.
    sched_clean(); run_txn(3'd5, 1'b0, 1'b0, 1'b0, 2'd2, 0, 0);
    // Stall for three cycles on the way into OPER.
    sched_clean(); rdy_sched[1] = 1'b0; rdy_sched[2] = 1'b0; rdy_sched[3] = 1'b0;
    run_txn(3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0);
    // Illegal ops.
    sched_clean(); run_txn(3'd7, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
    sched_clean(); run_txn(3'd6, 1'b1, 1'b0, 1'b0, 2'd3, 0, 0);
    // Remaining ops and BCD add.
    sched_clean(); run_txn(3'd2, 1'b0, 1'b0, 1'b1, 2'd1, 0, 0);
    sched_clean(); run_txn(3'd3, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0);
    sched_clean(); run_txn(3'd4, 1'b1, 1'b1, 1'b1, 2'd3, 0, 0);
    sched_clean(); run_txn(3'd0, 1'b0, 1'b1, 1'b0, 2'd3, 0, 0);
    // Reset during STORE of byte 1 of a 4-byte SUM, carry set beforehand.
    sched_clean(); ncout_sched[3] = 1'b0;
    run_txn(3'd0, 1'b1, 1'b0, 1'b0, 2'd3, 6, 0);
    repeat (2) @(negedge clk);

    // Randomized requests with random stalls and stray req pulses.
    for (int t = 0; t < 40; t++) begin
      sched_random();
      run_txn(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
